execute_flag_register_stack: RTL and testbench

//  Parametrised successor to the execute-stage flags register: a FLAG_W-bit flags register written by SRC_N priority-ordered units.

---
 rtl/execute_flag_register_stack.sv | 136 +++++++++++++
 tb/tb_execute_flag_register_stack.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/execute_flag_register_stack.sv
// Execute-stage flags register with priority-ordered producer units, a direct
// write port, a LIFO save/restore stack for exception entry/return, and a
// same-cycle bypass of the value the register takes at the next edge.
module execute_flag_register_stack #(
  parameter int FLAG_W      = 5,
  parameter int SRC_N       = 4,
  parameter int STACK_DEPTH = 4,
  parameter int PTR_W       = 3
) (
  input  logic                      iCLOCK,
  input  logic                      iRESET,
  input  logic                      iRESET_SYNC,
  input  logic                      iCTRL_HOLD,
  input  logic                      iPREV_INST_VALID,
  input  logic                      iPREV_BUSY,
  input  logic                      iPREV_FLAG_WRITE,
  input  logic [SRC_N-1:0]          iSRC_VALID,
  input  logic [SRC_N*FLAG_W-1:0]   iSRC_FLAG,
  input  logic                      iWR_VALID,
  input  logic [FLAG_W-1:0]         iWR_FLAG,
  input  logic                      iPUSH,
  input  logic                      iPOP,
  output logic [FLAG_W-1:0]         oFLAG,
  output logic [FLAG_W-1:0]         oFLAG_NEXT,
  output logic [PTR_W-1:0]          oSTACK_COUNT,
  output logic                      oSTACK_FULL,
  output logic                      oSTACK_EMPTY,
  output logic                      oERR_OVERFLOW,
  output logic                      oERR_UNDERFLOW,
  output logic                      oERR_CONFLICT
);

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [FLAG_W-1:0] flagReg;
  logic [FLAG_W-1:0] flagNext;
  logic [FLAG_W-1:0] stackMem [STACK_DEPTH];
  logic [PTR_W-1:0]  stackCount;
  logic              stackFull;
  logic              stackEmpty;
  logic [IDX_W-1:0]  pushIdx;
  logic [IDX_W-1:0]  topIdx;
  logic              srcHit;
  logic [FLAG_W-1:0] srcFlag;
  logic              instUpdate;
  logic              active;
  logic              conflict;
  logic              popReq;
  logic              pushReq;
  logic              errOverflow;
  logic              errUnderflow;
  logic              errConflict;

  assign stackFull  = (stackCount == PTR_W'(STACK_DEPTH));
  assign stackEmpty = (stackCount == '0);
  assign pushIdx    = IDX_W'(stackCount);
  assign topIdx     = IDX_W'(stackCount - PTR_W'(1));

  // Hold freezes everything; push and pop together is an error, not an action.
  assign active   = !iCTRL_HOLD && !iRESET_SYNC;
  assign conflict = active && iPUSH && iPOP;
  assign popReq   = active && iPOP && !iPUSH;
  assign pushReq  = active && iPUSH && !iPOP;

  // Select the lowest-index valid producer (index 0 has highest priority).
  always_comb begin
    srcHit  = 1'b0;
    srcFlag = '0;
    for (int k = SRC_N - 1; k >= 0; k--) begin
      if (iSRC_VALID[k]) begin
        srcHit  = 1'b1;
        srcFlag = iSRC_FLAG[k*FLAG_W +: FLAG_W];
      end
    end
    instUpdate = iPREV_INST_VALID && !iPREV_BUSY && iPREV_FLAG_WRITE && srcHit;
  end

  // Next flag value: restore beats direct write beats instruction update.
  always_comb begin
    flagNext = flagReg;
    if (iRESET_SYNC) begin
      flagNext = '0;
    end else if (iCTRL_HOLD || conflict) begin
      flagNext = flagReg;
    end else if (popReq) begin
      if (!stackEmpty) flagNext = stackMem[topIdx];
    end else if (iWR_VALID) begin
      flagNext = iWR_FLAG;
    end else if (instUpdate) begin
      flagNext = srcFlag;
    end
  end

  // Stack storage saves the pre-update flags; contents need no reset.
  always_ff @(posedge iCLOCK) begin
    if (pushReq && !stackFull) stackMem[pushIdx] <= flagReg;
  end

  // Flags, occupancy count and sticky error bits.
  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      flagReg      <= '0;
      stackCount   <= '0;
      errOverflow  <= 1'b0;
      errUnderflow <= 1'b0;
      errConflict  <= 1'b0;
    end else if (iRESET_SYNC) begin
      flagReg      <= '0;
      stackCount   <= '0;
      errOverflow  <= 1'b0;
      errUnderflow <= 1'b0;
      errConflict  <= 1'b0;
    end else if (!iCTRL_HOLD) begin
      flagReg <= flagNext;
      if (conflict) begin
        errConflict <= 1'b1;
      end else if (popReq) begin
        if (stackEmpty) errUnderflow <= 1'b1;
        else            stackCount   <= stackCount - PTR_W'(1);
      end else if (pushReq) begin
        if (stackFull) errOverflow <= 1'b1;
        else           stackCount  <= stackCount + PTR_W'(1);
      end
    end
  end

  assign oFLAG          = flagReg;
  assign oFLAG_NEXT     = flagNext;
  assign oSTACK_COUNT   = stackCount;
  assign oSTACK_FULL    = stackFull;
  assign oSTACK_EMPTY   = stackEmpty;
  assign oERR_OVERFLOW  = errOverflow;
  assign oERR_UNDERFLOW = errUnderflow;
  assign oERR_CONFLICT  = errConflict;

endmodule

// File: tb/tb_execute_flag_register_stack.sv
// Directed bench for execute_flag_register_stack: a vector table walked one
// cycle per entry, then hand-written reset sequences.
module tb_execute_flag_register_stack;

  logic        iCLOCK = 1'b0;
  logic        iRESET;
  logic        iRESET_SYNC;
  logic        iCTRL_HOLD;
  logic        iPREV_INST_VALID;
  logic        iPREV_BUSY;
  logic        iPREV_FLAG_WRITE;
  logic [3:0]  iSRC_VALID;
  logic [19:0] iSRC_FLAG;
  logic        iWR_VALID;
  logic [4:0]  iWR_FLAG;
  logic        iPUSH;
  logic        iPOP;
  logic [4:0]  oFLAG;
  logic [4:0]  oFLAG_NEXT;
  logic [2:0]  oSTACK_COUNT;
  logic        oSTACK_FULL;
  logic        oSTACK_EMPTY;
  logic        oERR_OVERFLOW;
  logic        oERR_UNDERFLOW;
  logic        oERR_CONFLICT;

  execute_flag_register_stack #(
    .FLAG_W(5), .SRC_N(4), .STACK_DEPTH(4), .PTR_W(3)
  ) dut (
    .iCLOCK(iCLOCK), .iRESET(iRESET), .iRESET_SYNC(iRESET_SYNC),
    .iCTRL_HOLD(iCTRL_HOLD), .iPREV_INST_VALID(iPREV_INST_VALID),
    .iPREV_BUSY(iPREV_BUSY), .iPREV_FLAG_WRITE(iPREV_FLAG_WRITE),
    .iSRC_VALID(iSRC_VALID), .iSRC_FLAG(iSRC_FLAG),
    .iWR_VALID(iWR_VALID), .iWR_FLAG(iWR_FLAG),
    .iPUSH(iPUSH), .iPOP(iPOP),
    .oFLAG(oFLAG), .oFLAG_NEXT(oFLAG_NEXT), .oSTACK_COUNT(oSTACK_COUNT),
    .oSTACK_FULL(oSTACK_FULL), .oSTACK_EMPTY(oSTACK_EMPTY),
    .oERR_OVERFLOW(oERR_OVERFLOW), .oERR_UNDERFLOW(oERR_UNDERFLOW),
    .oERR_CONFLICT(oERR_CONFLICT)
  );

  always #5 iCLOCK = ~iCLOCK;

  typedef struct {
    logic        hold;
    logic        instV;
    logic        busy;
    logic        fw;
    logic [3:0]  srcV;
    logic [19:0] srcF;
    logic        wrV;
    logic [4:0]  wrF;
    logic        push;
    logic        pop;
    logic [4:0]  expNext;
    logic [4:0]  expFlag;
    logic [2:0]  expCount;
    logic [2:0]  expErr;   // {overflow, underflow, conflict}
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(logic hold, logic instV, logic busy, logic fw,
                              logic [3:0] srcV, logic [19:0] srcF,
                              logic wrV, logic [4:0] wrF, logic push, logic pop,
                              logic [4:0] expNext, logic [4:0] expFlag,
                              logic [2:0] expCount, logic [2:0] expErr);
    vec_t v;
    v.hold = hold; v.instV = instV; v.busy = busy; v.fw = fw;
    v.srcV = srcV; v.srcF = srcF; v.wrV = wrV; v.wrF = wrF;
    v.push = push; v.pop = pop; v.expNext = expNext; v.expFlag = expFlag;
    v.expCount = expCount; v.expErr = expErr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idleInputs();
    iRESET_SYNC = 1'b0; iCTRL_HOLD = 1'b0;
    iPREV_INST_VALID = 1'b0; iPREV_BUSY = 1'b0; iPREV_FLAG_WRITE = 1'b0;
    iSRC_VALID = '0; iSRC_FLAG = '0; iWR_VALID = 1'b0; iWR_FLAG = '0;
    iPUSH = 1'b0; iPOP = 1'b0;
  endtask

  task automatic chkState(input string tag, input logic [4:0] f, input logic [2:0] c,
                          input logic [2:0] e);
    chk({tag, ".flag"},  32'(oFLAG), 32'(f));
    chk({tag, ".count"}, 32'(oSTACK_COUNT), 32'(c));
    chk({tag, ".full"},  32'(oSTACK_FULL), 32'(c == 3'd4));
    chk({tag, ".empty"}, 32'(oSTACK_EMPTY), 32'(c == 3'd0));
    chk({tag, ".err"},   32'({oERR_OVERFLOW, oERR_UNDERFLOW, oERR_CONFLICT}), 32'(e));
  endtask

  // One cycle of stack build-up: push with a direct write of the given flags.
  task automatic pushWrite(input logic [4:0] f);
    @(negedge iCLOCK);
    idleInputs();
    iPUSH = 1'b1; iWR_VALID = 1'b1; iWR_FLAG = f;
    @(negedge iCLOCK);
    idleInputs();
  endtask

  initial begin
    // Priority among producers and instruction gating.
    vecs.push_back(mk(0,1,0,1, 4'b1010, {5'h1F,5'h00,5'h0A,5'h00}, 0,5'h00, 0,0, 5'h0A,5'h0A,3'd0,3'b000));
    vecs.push_back(mk(0,1,1,1, 4'b0010, {5'h00,5'h00,5'h05,5'h00}, 0,5'h00, 0,0, 5'h0A,5'h0A,3'd0,3'b000));
    vecs.push_back(mk(0,1,0,0, 4'b0010, {5'h00,5'h00,5'h05,5'h00}, 0,5'h00, 0,0, 5'h0A,5'h0A,3'd0,3'b000));
    vecs.push_back(mk(0,1,0,1, 4'b0000, {5'h00,5'h00,5'h05,5'h00}, 0,5'h00, 0,0, 5'h0A,5'h0A,3'd0,3'b000));
    vecs.push_back(mk(0,1,0,1, 4'b0011, {5'h00,5'h00,5'h0A,5'h03}, 0,5'h00, 0,0, 5'h03,5'h03,3'd0,3'b000));
    vecs.push_back(mk(0,1,0,1, 4'b0001, {5'h00,5'h00,5'h00,5'h1F}, 1,5'h01, 0,0, 5'h01,5'h01,3'd0,3'b000));
    // Nesting: save 01..04, overflow on the fifth push, unwind in LIFO order.
    vecs.push_back(mk(0,0,0,0, 4'b0000, 20'h0, 1,5'h02, 1,0, 5'h02,5'h02,3'd1,3'b000));
    vecs.push_back(mk(0,0,0,0, 4'b0000, 20'h0, 1,5'h03, 1,0, 5'h03,5'h03,3'd2,3'b000));
    vecs.push_back(mk(0,0,0,0, 4'b0000, 20'h0, 1,5'h04, 1,0, 5'h04,5'h04,3'd3,3'b000));
    vecs.push_back(mk(0,0,0,0, 4'b0000, 20'h0, 0,5'h00, 1,0, 5'h04,5'h04,3'd4,3'b000));
    vecs.push_back(mk(0,0,0,0, 4'b0000, 20'h0, 1,5'h1F, 1,0, 5'h1F,5'h1F,3'd4,3'b100));
    vecs.push_back(mk(0,0,0,0, 4'b0000, 20'h0, 0,5'h00, 0,1, 5'h04,5'h04,3'd3,3'b100));
    vecs.push_back(mk(0,0,0,0, 4'b0000, 20'h0, 0,5'h00, 0,1, 5'h03,5'h03,3'd2,3'b100));
    vecs.push_back(mk(0,0,0,0, 4'b0000, 20'h0, 0,5'h00, 0,1, 5'h02,5'h02,3'd1,3'b100));
    vecs.push_back(mk(0,0,0,0, 4'b0000, 20'h0, 0,5'h00, 0,1, 5'h01,5'h01,3'd0,3'b100));
    // Underflow, then it must stay set through idle cycles.
    vecs.push_back(mk(0,0,0,0, 4'b0000, 20'h0, 1,5'h15, 0,0, 5'h15,5'h15,3'd0,3'b100));
    vecs.push_back(mk(0,0,0,0, 4'b0000, 20'h0, 0,5'h00, 0,1, 5'h15,5'h15,3'd0,3'b110));
    for (int i = 0; i < 10; i++)
      vecs.push_back(mk(0,0,0,0, 4'b0000, 20'h0, 0,5'h00, 0,0, 5'h15,5'h15,3'd0,3'b110));
    // Same-cycle save plus update, then restore beating a direct write.
    vecs.push_back(mk(0,0,0,0, 4'b0000, 20'h0, 1,5'h07, 0,0, 5'h07,5'h07,3'd0,3'b110));
    vecs.push_back(mk(0,1,0,1, 4'b0100, {5'h00,5'h11,5'h00,5'h00}, 0,5'h00, 1,0, 5'h11,5'h11,3'd1,3'b110));
    vecs.push_back(mk(0,0,0,0, 4'b0000, 20'h0, 1,5'h1C, 0,1, 5'h07,5'h07,3'd0,3'b110));
    // Conflict and hold.
    vecs.push_back(mk(0,0,0,0, 4'b0000, 20'h0, 1,5'h09, 1,0, 5'h09,5'h09,3'd1,3'b110));
    vecs.push_back(mk(0,0,0,0, 4'b0000, 20'h0, 1,5'h1A, 1,1, 5'h09,5'h09,3'd1,3'b111));
    vecs.push_back(mk(1,0,0,0, 4'b0000, 20'h0, 1,5'h12, 0,1, 5'h09,5'h09,3'd1,3'b111));
    vecs.push_back(mk(1,0,0,0, 4'b0000, 20'h0, 0,5'h00, 1,0, 5'h09,5'h09,3'd1,3'b111));
    vecs.push_back(mk(0,0,0,0, 4'b0000, 20'h0, 0,5'h00, 0,1, 5'h07,5'h07,3'd0,3'b111));
    // Only the lowest-priority unit valid.
    vecs.push_back(mk(0,1,0,1, 4'b1000, {5'h1F,5'h00,5'h00,5'h00}, 0,5'h00, 0,0, 5'h1F,5'h1F,3'd0,3'b111));

    idleInputs();
    iRESET = 1'b1;
    repeat (2) @(negedge iCLOCK);
    iRESET = 1'b0;
    #1;
    chkState("reset", 5'h00, 3'd0, 3'b000);

    foreach (vecs[i]) begin
      @(negedge iCLOCK);
      iCTRL_HOLD = vecs[i].hold; iPREV_INST_VALID = vecs[i].instV;
      iPREV_BUSY = vecs[i].busy; iPREV_FLAG_WRITE = vecs[i].fw;
      iSRC_VALID = vecs[i].srcV; iSRC_FLAG = vecs[i].srcF;
      iWR_VALID = vecs[i].wrV; iWR_FLAG = vecs[i].wrF;
      iPUSH = vecs[i].push; iPOP = vecs[i].pop;
      #1;
      chk($sformatf("v%0d.next", i), 32'(oFLAG_NEXT), 32'(vecs[i].expNext));
      @(posedge iCLOCK);
      #1;
      chkState($sformatf("v%0d", i), vecs[i].expFlag, vecs[i].expCount, vecs[i].expErr);
    end

    // Async reset mid-stack: count 2, flags 1E, conflict error set.
    pushWrite(5'h1E);
    pushWrite(5'h1E);
    chkState("preAsync", 5'h1E, 3'd2, 3'b111);
    #2;
    iRESET = 1'b1;
    #1;
    chkState("asyncReset", 5'h00, 3'd0, 3'b000);
    @(negedge iCLOCK);
    iRESET = 1'b0;

    // Sync reset while held: nothing until the edge, then cleared.
    pushWrite(5'h1E);
    pushWrite(5'h1E);
    @(negedge iCLOCK);
    iPUSH = 1'b1; iPOP = 1'b1;
    @(negedge iCLOCK);
    idleInputs();
    chkState("preSync", 5'h1E, 3'd2, 3'b001);
    iCTRL_HOLD = 1'b1;
    iRESET_SYNC = 1'b1;
    #1;
    chkState("syncBeforeEdge", 5'h1E, 3'd2, 3'b001);
    @(posedge iCLOCK);
    #1;
    chkState("syncAfterEdge", 5'h00, 3'd0, 3'b000);
    @(negedge iCLOCK);
    idleInputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
